// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage feeding the IF/ID register.
// Keeps the PC, talks to a variable-latency instruction memory over req/ack,
// and presents a registered instruction word, its PC+4 and a valid flag.
// Hazard stalls hold the outputs. Branch/jump redirects flush and insert bubbles.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] instruction_memory,
    output logic [31:0] pc_next,
    output logic        fetch_valid
);

    // FETCH: request to addr_q outstanding (addr_q == pc).
    // HOLD:  a fetched word is parked while the stall lasts; memory is idle.
    // FLUSH: a request made before a redirect is still in flight and its data
    //        must be thrown away. pc already holds the target.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_next_q, pc_next_d;
    logic        valid_q, valid_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;

    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic [31:0] hold_plus4;

    assign target     = redirect_pc & ~32'h3;
    assign pc_plus4   = pc_q + 32'd4;
    assign hold_plus4 = hold_pc_q + 32'd4;

    assign imem_req           = !rst && (state_q != HOLD);
    assign imem_addr          = addr_q;
    assign instruction_memory = instr_q;
    assign pc_next            = pc_next_q;
    assign fetch_valid        = valid_q;

    // Next-state and output-register logic; priority redirect > stall > normal.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        instr_d      = instr_q;
        pc_next_d    = pc_next_q;
        valid_d      = valid_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;

        case (state_q)
            FETCH: begin
                if (redirect) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    pc_d    = target;
                    if (imem_ack) begin
                        addr_d = target;
                    end else begin
                        // Old request still pending: keep its address stable.
                        state_d = FLUSH;
                    end
                end else if (imem_ack && stall) begin
                    hold_instr_d = imem_rdata;
                    hold_pc_d    = pc_q;
                    state_d      = HOLD;
                end else if (imem_ack) begin
                    instr_d   = imem_rdata;
                    pc_next_d = pc_plus4;
                    valid_d   = 1'b1;
                    pc_d      = pc_plus4;
                    addr_d    = pc_plus4;
                end else if (!stall) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (redirect) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    pc_d    = target;
                    addr_d  = target;
                    state_d = FETCH;
                end else if (!stall) begin
                    instr_d   = hold_instr_q;
                    pc_next_d = hold_plus4;
                    valid_d   = 1'b1;
                    pc_d      = hold_plus4;
                    addr_d    = hold_plus4;
                    state_d   = FETCH;
                end
            end
            FLUSH: begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
                if (redirect) begin
                    pc_d = target;
                end
                if (imem_ack) begin
                    addr_d  = redirect ? target : pc_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            instr_q      <= NOP_INSTR;
            pc_next_q    <= RESET_PC;
            valid_q      <= 1'b0;
            hold_instr_q <= 32'h0;
            hold_pc_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            instr_q      <= instr_d;
            pc_next_q    <= pc_next_d;
            valid_q      <= valid_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed stalls/redirects/resets against a
// configurable-latency memory, a transaction-level model checked every cycle,
// and literal expectations at the interesting points.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] instruction_memory;
    logic [31:0] pc_next;
    logic        fetch_valid;

    // Second instance: reset vector at the top of the address space, zero-wait memory.
    logic        req2;
    logic [31:0] addr2;
    logic [31:0] instr2;
    logic [31:0] pcn2;
    logic        valid2;
    logic        tie0;

    int wait_states;
    int wait_cnt;
    int n_pass;
    int n_total;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hC0DE_0001;
    endfunction

    if_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .instruction_memory(instruction_memory), .pc_next(pc_next),
        .fetch_valid(fetch_valid)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut_wrap (
        .clk(clk), .rst(rst), .stall(tie0), .redirect(tie0),
        .redirect_pc(32'h0), .imem_req(req2), .imem_addr(addr2),
        .imem_rdata(word(addr2)), .imem_ack(req2),
        .instruction_memory(instr2), .pc_next(pcn2), .fetch_valid(valid2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: acknowledges after wait_states cycles of continuous request.
    assign imem_ack   = imem_req && (wait_cnt >= wait_states);
    assign imem_rdata = word(imem_addr);

    always @(posedge clk) begin
        if (!imem_req || imem_ack) wait_cnt <= 0;
        else                       wait_cnt <= wait_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // ---------------- transaction-level model ----------------
    logic [31:0] m_pc, m_req_addr, m_instr, m_pcn, m_buf_word, m_buf_pc;
    logic        m_valid, m_stale, m_buf, m_ready;
    logic        s_rst, s_red, s_stall, s_ack;
    logic [31:0] s_tgt, s_rdata;

    task automatic model_bubble();
        m_instr = NOP;
        m_valid = 1'b0;
    endtask

    task automatic model_step();
        if (s_rst) begin
            m_pc = 32'h0; m_req_addr = 32'h0; m_stale = 0; m_buf = 0;
            m_instr = NOP; m_pcn = 32'h0; m_valid = 0;
        end else if (m_buf) begin
            if (s_red) begin
                m_buf = 0; m_pc = s_tgt; m_req_addr = s_tgt; model_bubble();
            end else if (!s_stall) begin
                m_buf = 0; m_instr = m_buf_word; m_pcn = m_buf_pc + 4; m_valid = 1;
                m_pc = m_buf_pc + 4; m_req_addr = m_pc;
            end
        end else if (m_stale) begin
            model_bubble();
            if (s_red) m_pc = s_tgt;
            if (s_ack) begin m_stale = 0; m_req_addr = m_pc; end
        end else if (s_red) begin
            model_bubble();
            m_pc = s_tgt;
            if (s_ack) m_req_addr = s_tgt;
            else       m_stale = 1;
        end else if (s_ack && s_stall) begin
            m_buf = 1; m_buf_word = s_rdata; m_buf_pc = m_pc;
        end else if (s_ack) begin
            m_instr = s_rdata; m_pcn = m_pc + 4; m_valid = 1;
            m_pc = m_pc + 4; m_req_addr = m_pc;
        end else if (!s_stall) begin
            model_bubble();
        end
    endtask

    // Compare process: request side mid-cycle, registered outputs after the edge.
    initial m_ready = 1'b0;
    always begin
        @(negedge clk); #2;
        if (m_ready) begin
            check("model_req", {31'h0, imem_req}, {31'h0, (!rst && !m_buf)});
            check("model_addr", imem_addr, m_req_addr);
        end
        s_rst = rst; s_red = redirect; s_stall = stall; s_ack = imem_ack;
        s_rdata = imem_rdata; s_tgt = {redirect_pc[31:2], 2'b00};
        @(posedge clk); #1;
        model_step();
        if (s_rst) m_ready = 1'b1;
        if (m_ready) begin
            check("model_instr", instruction_memory, m_instr);
            check("model_pcn", pc_next, m_pcn);
            check("model_valid", {31'h0, fetch_valid}, {31'h0, m_valid});
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        n_pass = 0; n_total = 0;
        rst = 1; stall = 0; redirect = 0; redirect_pc = 0; wait_states = 0; tie0 = 0;
        repeat (2) @(negedge clk);
        check("rst_instr", instruction_memory, NOP);
        check("rst_pcn", pc_next, 32'h0);
        check("rst_valid", {31'h0, fetch_valid}, 32'h0);
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_wrap_pcn", pcn2, 32'hFFFF_FFFC);
        rst = 0;

        // Zero-wait streaming.
        @(negedge clk);
        check("zw_pcn1", pc_next, 32'h4);
        check("zw_valid1", {31'h0, fetch_valid}, 32'h1);
        check("wrap_pcn", pcn2, 32'h0);
        check("wrap_instr", instr2, word(32'hFFFF_FFFC));
        check("wrap_addr", addr2, 32'h0);
        repeat (3) @(negedge clk);
        check("zw_pcn4", pc_next, 32'h10);
        check("zw_instr4", instruction_memory, word(32'hC));
        check("zw_addr", imem_addr, 32'h10);
        check("wrap_pcn4", pcn2, 32'hC);

        // Stall with ack at 0x10 for three cycles.
        stall = 1;
        @(negedge clk);
        check("hold_req", {31'h0, imem_req}, 32'h0);
        check("hold_pcn", pc_next, 32'h10);
        repeat (2) @(negedge clk);
        check("hold_pcn3", pc_next, 32'h10);
        check("hold_instr3", instruction_memory, word(32'hC));
        stall = 0;
        @(negedge clk);
        check("rel_pcn", pc_next, 32'h14);
        check("rel_instr", instruction_memory, word(32'h10));
        check("rel_addr", imem_addr, 32'h14);

        // Two wait states.
        wait_states = 2;
        @(negedge clk);
        check("ws_bubble_valid", {31'h0, fetch_valid}, 32'h0);
        check("ws_bubble_instr", instruction_memory, NOP);
        check("ws_addr_stable", imem_addr, 32'h14);
        repeat (2) @(negedge clk);
        check("ws_pcn", pc_next, 32'h18);
        check("ws_instr", instruction_memory, word(32'h14));

        // Redirect to 0x20, then redirect to 0x103 while 0x20 is pending.
        wait_states = 3; redirect = 1; redirect_pc = 32'h20;
        @(negedge clk);
        redirect = 0;
        repeat (3) @(negedge clk);
        check("fl1_addr", imem_addr, 32'h20);
        @(negedge clk);
        redirect = 1; redirect_pc = 32'h103;
        @(negedge clk);
        redirect = 0;
        check("fl2_addr_old", imem_addr, 32'h20);
        check("fl2_valid", {31'h0, fetch_valid}, 32'h0);
        repeat (2) @(negedge clk);
        check("fl2_addr_new", imem_addr, 32'h100);
        repeat (4) @(negedge clk);
        check("fl2_pcn", pc_next, 32'h104);
        check("fl2_instr", instruction_memory, word(32'h100));

        // Redirect and stall together with ack: redirect wins.
        wait_states = 0; stall = 1; redirect = 1; redirect_pc = 32'h200;
        @(negedge clk);
        stall = 0; redirect = 0;
        check("rs_valid", {31'h0, fetch_valid}, 32'h0);
        check("rs_pcn", pc_next, 32'h104);
        check("rs_addr", imem_addr, 32'h200);
        check("rs_req", {31'h0, imem_req}, 32'h1);
        @(negedge clk);
        check("rs_next_pcn", pc_next, 32'h204);
        check("rs_next_instr", instruction_memory, word(32'h200));

        // Reset in the middle of a wait.
        wait_states = 2;
        @(negedge clk);
        rst = 1;
        #2;
        check("mr_req", {31'h0, imem_req}, 32'h0);
        @(negedge clk);
        check("mr_instr", instruction_memory, NOP);
        check("mr_pcn", pc_next, 32'h0);
        check("mr_valid", {31'h0, fetch_valid}, 32'h0);
        check("mr_addr", imem_addr, 32'h0);
        rst = 0;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
